// File: rtl/delay_cal_seq.sv
// Calibration sequencer: fires single-cycle triggers into the pulse generator and
// timestamps the first above-threshold ADC sample after each one to report loop latency.
module delay_cal_seq #(
    parameter int SAMPLES  = 16,
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [2:0]                         trials_log2,
    input  logic [SAMPLE_W-1:0]                threshold,
    input  logic [CNT_W-1:0]                   timeout,
    input  logic [CNT_W-1:0]                   gap,
    output logic                               trig_out,
    input  logic                               adc_valid,
    input  logic [SAMPLES*SAMPLE_W-1:0]        adc_word,
    output logic                               busy,
    output logic                               done,
    output logic                               err_timeout,
    output logic [CNT_W+$clog2(SAMPLES)-1:0]   min_delay,
    output logic [CNT_W+$clog2(SAMPLES)-1:0]   max_delay,
    output logic [CNT_W+$clog2(SAMPLES)-1:0]   avg_delay
);

    localparam int LOG_S = $clog2(SAMPLES);
    localparam int D_W   = CNT_W + LOG_S;
    localparam int ACC_W = D_W + 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT_ECHO,
        S_GAP,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          tlog_q, tlog_d;
    logic [SAMPLE_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    gcnt_q, gcnt_d;
    logic [7:0]          trial_q, trial_d;
    logic [ACC_W-1:0]    sum_q, sum_d;
    logic [D_W-1:0]      min_q, min_d;
    logic [D_W-1:0]      max_q, max_d;
    logic                err_q, err_d;
    logic [D_W-1:0]      min_out_q, min_out_d;
    logic [D_W-1:0]      max_out_q, max_out_d;
    logic [D_W-1:0]      avg_out_q, avg_out_d;

    logic [SAMPLES-1:0]  above;
    logic                hit;
    logic [LOG_S-1:0]    fine;
    logic [D_W-1:0]      total;
    logic [7:0]          trial_inc;
    logic [7:0]          target;

    // Per-sample signed strict comparison, qualified by adc_valid.
    genvar gi;
    generate
        for (gi = 0; gi < SAMPLES; gi++) begin : g_cmp
            assign above[gi] = adc_valid &&
                ($signed(adc_word[gi*SAMPLE_W +: SAMPLE_W]) > $signed(thr_q));
        end
    endgenerate

    // Lowest set index wins: scan downward so the last assignment is the earliest sample.
    always_comb begin
        fine = '0;
        for (int i = SAMPLES - 1; i >= 0; i--) begin
            if (above[i]) fine = LOG_S'(i);
        end
    end

    assign hit       = |above;
    assign total     = {cnt_q, fine};
    assign trial_inc = trial_q + 8'd1;
    assign target    = 8'd1 << tlog_q;

    always_comb begin
        state_d   = state_q;
        tlog_d    = tlog_q;
        thr_d     = thr_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        trial_d   = trial_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        err_d     = err_q;
        min_out_d = min_out_q;
        max_out_d = max_out_q;
        avg_out_d = avg_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tlog_d  = trials_log2;
                    thr_d   = threshold;
                    tmo_d   = timeout;
                    gap_d   = gap;
                    err_d   = 1'b0;
                    sum_d   = '0;
                    min_d   = '1;
                    max_d   = '0;
                    trial_d = '0;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                // Preloaded to 1 so the first WAIT_ECHO cycle already carries count 1.
                cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                state_d = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                cnt_d = cnt_q + 1'b1;
                if (hit) begin
                    sum_d   = sum_q + ACC_W'(total);
                    min_d   = (total < min_q) ? total : min_q;
                    max_d   = (total > max_q) ? total : max_q;
                    trial_d = trial_inc;
                    if (gap_q != '0) begin
                        gcnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d = S_GAP;
                    end else if (trial_inc == target) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_FIRE;
                    end
                end else if (cnt_q == tmo_q) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_GAP: begin
                if (gcnt_q == gap_q) begin
                    state_d = (trial_q == target) ? S_FINISH : S_FIRE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Results are loaded on entry to FINISH so they are already valid alongside done.
        if (state_q != S_FINISH && state_d == S_FINISH && !err_d) begin
            min_out_d = min_d;
            max_out_d = max_d;
            avg_out_d = D_W'(sum_d >> tlog_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tlog_q    <= '0;
            thr_q     <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            trial_q   <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            err_q     <= 1'b0;
            min_out_q <= '0;
            max_out_q <= '0;
            avg_out_q <= '0;
        end else begin
            state_q   <= state_d;
            tlog_q    <= tlog_d;
            thr_q     <= thr_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            trial_q   <= trial_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            err_q     <= err_d;
            min_out_q <= min_out_d;
            max_out_q <= max_out_d;
            avg_out_q <= avg_out_d;
        end
    end

    assign trig_out    = (state_q == S_FIRE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign err_timeout = err_q;
    assign min_delay   = min_out_q;
    assign max_delay   = max_out_q;
    assign avg_delay   = avg_out_q;

endmodule

// File: doc/delay_cal_seq.md
Name: delay_cal_seq

Overview:
Sequencer that drives the calibration pulse generator's trig input and measures DAC-to-ADC loop latency in the RFSoC Ising machine datapath. It fires a programmable number of single-cycle triggers and timestamps the first ADC sample above a threshold after each trigger. It reports min, max and average total latency in sample units (cycles × samples/word + sample index). It sits between the control register block and the pulse generator / ADC capture path.

Parameters:
SAMPLES, 16, samples per 256-bit ADC word (power of two)
SAMPLE_W, 16, bits per sample, signed two's complement; SAMPLES*SAMPLE_W = 256
CNT_W, 16, width of the cycle counter and timeout

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin calibration run; sampled only in IDLE
trials_log2  in  3  run length = 2^trials_log2 trials (1..128)
threshold  in  SAMPLE_W  signed detection threshold
timeout  in  CNT_W  max cycles to wait for echo; must be nonzero
gap  in  CNT_W  idle cycles between detection/timeout and next fire
trig_out  out  1  to pulse generator trig
adc_valid  in  1  adc_word qualifier
adc_word  in  256  ADC samples; sample i = bits [i*SAMPLE_W +: SAMPLE_W]; i=0 earliest
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
err_timeout  out  1  last run aborted on timeout; sticky until next start
min_delay  out  CNT_W+log2(SAMPLES)  minimum total latency of last run
max_delay  out  CNT_W+log2(SAMPLES)  maximum total latency of last run
avg_delay  out  CNT_W+log2(SAMPLES)  sum >> trials_log2 (truncating)

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; counters, accumulator cleared.
- States: IDLE, FIRE, WAIT_ECHO, GAP, FINISH.
- IDLE: busy=0. start=1 -> latch trials_log2, threshold, timeout, gap; clear err_timeout; sum=0; internal min=all-ones, max=0; trial count=0; -> FIRE. start during any other state ignored.
- FIRE: one cycle; trig_out=1 (only state where trig_out is high, so the pulse generator always sees a single-cycle high and re-arms); cycle counter=0; -> WAIT_ECHO.
- WAIT_ECHO: counter increments every cycle regardless of adc_valid; first cycle in this state has count=1. Detection when adc_valid=1 and any sample > threshold (signed, strict). fine = lowest index i satisfying it; total = count*SAMPLES + fine. On detection: sum += total; update min/max; trial count++; -> GAP.
- Timeout: no detection and count == timeout -> err_timeout=1, -> FINISH without updating stats. Detection in that same cycle takes priority (valid trial, no error).
- GAP: trig_out=0, wait exactly gap cycles (gap=0 -> zero cycles). ADC data ignored. Then if trial count == 2^trials_log2 -> FINISH, else -> FIRE.
- FINISH: one cycle; done=1; if no error, load min_delay, max_delay, avg_delay; on error, stat outputs keep previous values; -> IDLE. busy=1 in FIRE through FINISH.
- Widths: total delay D = CNT_W+log2(SAMPLES) bits; accumulator D+7 bits, never overflows. Counter never wraps (timeout bounds it).
- Reset mid-run: immediate return to IDLE, trig_out=0, outputs cleared; no done pulse.

Test Plan:
- trials_log2=0, threshold=1000, echo sample 3 = 2000 in WAIT_ECHO count 5 -> done after gap, min=max=avg=83, err_timeout=0, exactly one trig_out pulse.
- trials_log2=2, echoes at totals 80, 81, 83, 86 -> four trig_out pulses each separated by ≥ gap+2 cycles; min=80, max=86, avg=82.
- timeout=10, no sample ever exceeds threshold -> err_timeout=1 and done at count 10; prior stat outputs unchanged; next start clears err_timeout.
- Echo arrives in the same cycle count reaches timeout -> counted as valid trial, err_timeout=0; samples 2 and 7 both above threshold -> fine=2; adc_valid=0 cycles with large samples -> ignored.
- start pulsed while busy and above-threshold data during GAP -> no restart, no extra trial, results unchanged.
- rst asserted during WAIT_ECHO -> all outputs 0 next edge, trig_out low, no done; new start afterwards runs normally.
